// File: rtl/pipeline_fetch_stage.sv
// Instruction fetch stage: PC generation, synchronous instruction memory, prefetch FIFO and
// valid/ready handoff to decode. Define IF_PERF_CNT_EN to add the perf_fetch_cnt/perf_flush_cnt counters.
module pipeline_fetch_stage #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    // Handshake: a transfer happens on a rising edge where id_valid && id_ready;
    // id_ir/id_pc stay stable while id_valid && !id_ready.
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [XLEN-1:0]               id_ir,
`ifdef IF_PERF_CNT_EN
    output logic [XLEN-1:0]               id_pc,
    output logic [31:0]                   perf_fetch_cnt,
    output logic [31:0]                   perf_flush_cnt
`else
    output logic [XLEN-1:0]               id_pc
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_mem [IMEM_DEPTH];
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;

    logic [XLEN-1:0] r_fifo_ir [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_pc [FIFO_DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CW-1:0]   w_level;
    logic [AW-1:0]   w_raddr;
    logic [XLEN-1:0] w_target;

    assign id_valid = (r_count != '0);
    assign id_ir    = id_valid ? r_fifo_ir[r_rd_ptr] : '0;
    assign id_pc    = id_valid ? r_fifo_pc[r_rd_ptr] : '0;

    assign w_pop    = id_valid && id_ready;
    // A read returning during a redirect belongs to the flushed path and is dropped.
    assign w_push   = r_inflight && !redirect_valid;
    // Occupancy after this cycle's pop, counting the read already in flight as a reserved slot.
    assign w_level  = r_count + CW'(r_inflight) - CW'(w_pop);
    assign w_issue  = (w_level < CW'(FIFO_DEPTH)) && !redirect_valid;
    assign w_raddr  = r_pc[AW+1:2];
    assign w_target = redirect_pc & ~XLEN'(3);

    // Memory is not reset; write and read share an edge so a colliding read returns old data.
    always_ff @(posedge clk) begin
        if (imem_we)
            r_mem[imem_waddr] <= imem_wdata;
        if (w_issue)
            r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_ir[r_wr_ptr] <= r_rdata;
            r_fifo_pc[r_wr_ptr] <= r_inflight_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_pc          <= w_target;
            r_inflight    <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + XLEN'(4);
                r_inflight_pc <= r_pc;
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_pop)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
